// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
//   clock, LSB first, with a single borrow flip-flop. start/busy/done handshake.
//   The result is held until the next completion.
//
//   Parameters
//     WIDTH   operand/result width in bits (>= 2)
//
//   Ports
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     start   in   request; a/b sampled on the edge where start is accepted
//     a       in   minuend
//     b       in   subtrahend
//     busy    out  high while bits are being processed
//     done    out  one-cycle pulse when diff/borrow have just been updated
//     diff    out  a - b mod 2^WIDTH, held until next completion
//     borrow  out  1 when a < b (unsigned), held with diff
//     ovf     out  two's-complement overflow flag, held with diff
//                  (present only when SERIAL_SUB_OVF_EN is defined)
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   // a_sr doubles as the result register: each new difference bit enters at
   // the MSB while the consumed minuend bit leaves at the LSB.
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             d;
   logic             br_next;
   logic             last_bit;
   logic             load;

`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // One full-subtractor cell on the current LSBs.
   always_comb begin
      d        = a_sr[0] ^ b_sr[0] ^ br;
      br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      last_bit = (cnt == LAST);
      load     = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else if (load) begin
         a_sr  <= a;
         b_sr  <= b;
         cnt   <= '0;
         br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_sr <= {d, a_sr[WIDTH-1:1]};
         b_sr <= b_sr >> 1;
         br   <= br_next;
         cnt  <= cnt + CW'(1);
         if (last_bit) begin
            // d is the result MSB on this final step.
            diff   <= {d, a_sr[WIDTH-1:1]};
            borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
         end
      end
   end

endmodule
